// File: rtl/sound_scheduler.sv
// sound_scheduler: shares the note_gen audio path between BGM and one-shot SFX, owns volume/mute.
// Optional: SOUND_SCHED_PREEMPT_EN lets a higher-priority request abort a playing effect on a tick.
// Ports: clk_i, rst_i (sync, active-high); sfx_req_i (one pulse bit per effect id);
//   vol_up_i/vol_down_i (one-pulse), mute_i (level); bgm_div_l_i/bgm_div_r_i (BGM dividers);
//   note_div_l_o/note_div_r_o (to note_gen), volume_o (0 muted, else 1..5),
//   sfx_busy_o (effect playing), sfx_id_o (granted effect id).
module sound_scheduler #(
  parameter int DIV_W       = 22,
  parameter int NUM_REQ     = 4,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int SFX_TICKS   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] sfx_req_i,
  input  logic               vol_up_i,
  input  logic               vol_down_i,
  input  logic               mute_i,
  input  logic [DIV_W-1:0]   bgm_div_l_i,
  input  logic [DIV_W-1:0]   bgm_div_r_i,
  output logic [DIV_W-1:0]   note_div_l_o,
  output logic [DIV_W-1:0]   note_div_r_o,
  output logic [2:0]         volume_o,
  output logic               sfx_busy_o,
  output logic [1:0]         sfx_id_o
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DUR_W = $clog2(SFX_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d, grant_mask;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [1:0]         id_q, id_d;
  logic [2:0]         vol_q, vol_d;
  logic               tick;
  logic               found;
  logic [1:0]         low_id;
  logic               preempt;
  logic [DIV_W-1:0]   sfx_div;

  // Lowest set pending index wins (index 0 is highest priority).
  always_comb begin
    found  = 1'b0;
    low_id = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found  = 1'b1;
        low_id = 2'(i);
      end
    end
  end

  assign tick = (state_q != IDLE) &&
                (cnt_q == CNT_W'(TICK_CYCLES - 1));

`ifdef SOUND_SCHED_PREEMPT_EN
  assign preempt = found && (low_id < id_q);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dur_d      = dur_q;
    id_d       = id_q;
    grant_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_mask = NUM_REQ'(1) << low_id;
          id_d       = low_id;
          dur_d      = DUR_W'(SFX_TICKS);
          cnt_d      = '0;
          state_d    = PLAY;
        end
      end
      PLAY: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (preempt) begin
            // Aborted effect is simply dropped, not re-queued.
            grant_mask = NUM_REQ'(1) << low_id;
            id_d       = low_id;
            dur_d      = DUR_W'(SFX_TICKS);
          end else if (dur_q == DUR_W'(1)) begin
            state_d = GAP;
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      GAP: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle re-request of the granted id survives the clear.
  assign pend_d = (pend_q & ~grant_mask) | sfx_req_i;

  always_comb begin
    vol_d = vol_q;
    if (!mute_i) begin
      if (vol_up_i && !vol_down_i && vol_q < 3'd5)
        vol_d = vol_q + 3'd1;
      else if (vol_down_i && !vol_up_i && vol_q > 3'd1)
        vol_d = vol_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      dur_q   <= '0;
      id_q    <= 2'd0;
      vol_q   <= 3'd3;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      id_q    <= id_d;
      vol_q   <= vol_d;
    end
  end

  always_comb begin
    unique case (id_q)
      2'd0:    sfx_div = DIV_W'(95_556);
      2'd1:    sfx_div = DIV_W'(127_551);
      2'd2:    sfx_div = DIV_W'(151_515);
      default: sfx_div = DIV_W'(191_113);
    endcase
  end

  assign sfx_busy_o   = (state_q == PLAY);
  assign sfx_id_o     = id_q;
  assign note_div_l_o = sfx_busy_o ? sfx_div : bgm_div_l_i;
  assign note_div_r_o = sfx_busy_o ? sfx_div : bgm_div_r_i;
  assign volume_o     = mute_i ? 3'd0 : vol_q;

endmodule
